conv_window_feeder: RTL and testbench
=====================================

// Module: conv_window_feeder
// PURPOSE
//  Upstream stage of the convolution accelerator. Takes a raster pixel stream and builds 3x3
//  windows with two line buffers. For each valid window it serialises 9 (weight, pixel) pairs
//  into the accelerator input FIFO, pulses cStart, and waits for cReady. It then returns
//  finalsum tagged with the window's output coordinate. One clock: accelerator wr_clk is tied to Clk.
// PARAMETERS
//  BIT_LENGTH  8  width of pixel, weight and result words (equals `bitLength)
//  IMG_WIDTH   8  pixels per line, >=3
//  IMG_HEIGHT  8  lines per frame, >=3
// PORTS
//  Clk        in   1           single clock, rising edge
//  RstIn      in   1           asynchronous, active-low reset
//  clear      in   1           sync abort: counters/FSM to reset state, weights and line buffers kept
//  wt_we      in   1           weight write strobe, honoured only in FILL
//  wt_addr    in   4           weight index 0..8, row-major; 9..15 ignored
//  wt_data    in   BIT_LENGTH  weight value
//  pix_valid  in   1           pixel offered
//  pix_ready  out  1           pixel accepted when pix_valid&&pix_ready
//  pix_data   in   BIT_LENGTH  pixel, raster order
//  acc_wr     out  1           FIFO write request (to accelerator wr)
//  acc_data   out  BIT_LENGTH  FIFO write data (to dataInput)
//  acc_full   in   1           accelerator FULL
//  acc_cstart out  1           one-cycle cStart pulse
//  acc_cready in   1           accelerator cReady (level)
//  acc_sum    in   BIT_LENGTH  accelerator finalsum
//  res_valid  out  1           one-cycle result strobe
//  res_data   out  BIT_LENGTH  captured finalsum
//  res_row    out  clog2(IMG_HEIGHT) output row = centre row-1 (0..IMG_HEIGHT-3)
//  res_col    out  clog2(IMG_WIDTH)  output col = centre col-1 (0..IMG_WIDTH-3)
//  frame_done out  1           one-cycle pulse after the last result of a frame
// BEHAVIOUR
//  Reset (RstIn=0, async): FSM=FILL, row=col=0. All outputs 0 except pix_ready=1. Weights=0. Line buffers undefined.
//  FSM: FILL -> PUSH -> START -> WAIT -> EMIT -> FILL.
//  FILL: pix_ready=1. On accept at (r,c):
//    - shift window left; new right column = {lb1[c], lb0[c], pix} (top..bottom);
//    - lb1[c]<=lb0[c]; lb0[c]<=pix; col++ (wrap at IMG_WIDTH, then row++).
//    - If r>=2 && c>=2 -> PUSH, else stay.
//  PUSH: pix_ready=0. 18 words, order w0,p0,w1,p1..w8,p8 (row-major). acc_wr=1 only when acc_full=0.
//    - Word index advances only on acc_wr&&!acc_full; full stalls hold acc_data stable.
//    - After word 17 is written -> START.
//  START: acc_cstart=1 for exactly one cycle -> WAIT.
//  WAIT: detect rising edge of acc_cready (registered prev). Capture acc_sum into res_data -> EMIT.
//    - cReady already high on entry does not count; it must fall and rise.
//  EMIT: res_valid=1 one cycle with res_row/res_col.
//    - If the window was (IMG_HEIGHT-1, IMG_WIDTH-1): frame_done=1 same cycle, row=col=0.
//    - -> FILL.
//  No further pixel is accepted between window detect and EMIT (latency >= 21 cycles per window).
//  Arithmetic: none; result is truncated finalsum as delivered, no saturation.
//  wt_we outside FILL is dropped (weights stable during a push).
//    - wt_we and pixel accept in the same FILL cycle: both take effect.
//    - The new weight is used from the next window.
//  clear: acts the next edge in any state; acc_wr/acc_cstart/res_valid drop immediately.
//    - In-flight accelerator result is ignored.
//    - Caller also resets the accelerator.
//  Async reset mid-PUSH/WAIT: immediate return to reset state; no partial result emitted.
// STRUCTURE
//  Shared package/header: FSM state encodings, PAIR_WORDS=18, WINDOW_TAPS=9, BIT_LENGTH default.
//  One sub-module: conv_line_buffer (two IMG_WIDTH x BIT_LENGTH single-port row stores, shift on write).
//  Window regs, weight file, counters and FSM live in the top.
// TESTING
//  1 IMG 4x4, weights all 1, pixels 1..16, acc model sums pairs
//    -> 4 results: 54,63,90,99 at (0,0),(0,1),(1,0),(1,1); frame_done with last.
//  2 Word order: weights 1..9, pixels 1..16
//    -> PUSH words = 1,1,2,2,3,3,4,5,5,6,6,7,7,9,8,10,9,11.
//  3 acc_full held high 5 cycles mid-PUSH
//    -> acc_wr stays low, acc_data stable, no word skipped or duplicated, still 18 writes.
//  4 acc_cready high before cStart
//    -> no capture until it falls and rises; then res_valid one cycle with acc_sum.
//  5 RstIn low during WAIT, and clear during PUSH
//    -> outputs at reset values, pix_ready=1, next frame results correct from (0,0).
//  6 wt_we during PUSH ignored; wt_we with pix accept in FILL applied to the next window only.

Source files
------------

// File: rtl/conv_window_feeder_pkg.sv
// Shared constants for the 3x3 convolution window feeder.
// FSM encodings and window/pair sizes.
package conv_window_feeder_pkg;

  localparam int BIT_LENGTH_DEF = 8;
  localparam int PAIR_WORDS     = 18;
  localparam int WINDOW_TAPS    = 9;

  localparam logic [2:0] S_FILL  = 3'd0;
  localparam logic [2:0] S_PUSH  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;

endpackage

// File: rtl/conv_line_buffer.sv
// Two stacked row stores; a write pushes the old
// row-1 value up into row-2 at the same column.
module conv_line_buffer
  import conv_window_feeder_pkg::*;
#(
  parameter int BIT_LENGTH = BIT_LENGTH_DEF,
  parameter int IMG_WIDTH  = 8,
  parameter int CW         = $clog2(IMG_WIDTH)
)(
  input  logic                  Clk,
  input  logic                  i_we,
  input  logic [CW-1:0]         i_col,
  input  logic [BIT_LENGTH-1:0] i_pix,
  output logic [BIT_LENGTH-1:0] o_lb0,
  output logic [BIT_LENGTH-1:0] o_lb1
);

  logic [BIT_LENGTH-1:0] r_lb0 [IMG_WIDTH];
  logic [BIT_LENGTH-1:0] r_lb1 [IMG_WIDTH];

  assign o_lb0 = r_lb0[i_col];
  assign o_lb1 = r_lb1[i_col];

  // Shift the column up one line on each accepted pixel.
  always_ff @(posedge Clk) begin
    if (i_we) begin
      r_lb1[i_col] <= r_lb0[i_col];
      r_lb0[i_col] <= i_pix;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Builds 3x3 windows from a raster stream and feeds
// weight/pixel pairs to the convolution accelerator.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int BIT_LENGTH = BIT_LENGTH_DEF,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
)(
  input  logic                          Clk,
  input  logic                          RstIn,
  input  logic                          clear,
  input  logic                          wt_we,
  input  logic [3:0]                    wt_addr,
  input  logic [BIT_LENGTH-1:0]         wt_data,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic [BIT_LENGTH-1:0]         pix_data,
  output logic                          acc_wr,
  output logic [BIT_LENGTH-1:0]         acc_data,
  input  logic                          acc_full,
  output logic                          acc_cstart,
  input  logic                          acc_cready,
  input  logic [BIT_LENGTH-1:0]         acc_sum,
  output logic                          res_valid,
  output logic [BIT_LENGTH-1:0]         res_data,
  output logic [$clog2(IMG_HEIGHT)-1:0] res_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  res_col,
  output logic                          frame_done
);

  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int CW = $clog2(IMG_WIDTH);

  logic [2:0]            r_state;
  logic [RW-1:0]         r_row;
  logic [CW-1:0]         r_col;
  logic [4:0]            r_widx;
  logic                  r_prev_rdy;
  logic [BIT_LENGTH-1:0] r_res;
  logic [RW-1:0]         r_orow;
  logic [CW-1:0]         r_ocol;
  logic                  r_last;
  logic [BIT_LENGTH-1:0] r_wt  [WINDOW_TAPS];
  logic [BIT_LENGTH-1:0] r_win [WINDOW_TAPS];

  logic                  w_accept;
  logic                  w_col_end;
  logic                  w_row_end;
  logic                  w_win;
  logic                  w_wr;
  logic                  w_edge;
  logic [3:0]            w_tap;
  logic [BIT_LENGTH-1:0] w_lb0;
  logic [BIT_LENGTH-1:0] w_lb1;

  assign pix_ready = (r_state == S_FILL);
  assign w_accept  = pix_valid && pix_ready && !clear;
  assign w_col_end = (r_col == CW'(IMG_WIDTH - 1));
  assign w_row_end = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_win     = (r_row >= RW'(2)) && (r_col >= CW'(2));
  assign w_wr      = (r_state == S_PUSH) && !acc_full && !clear;
  assign w_edge    = acc_cready && !r_prev_rdy;
  assign w_tap     = r_widx[4:1];

  assign acc_wr     = w_wr;
  assign acc_data   = (r_state != S_PUSH) ? '0 :
                      r_widx[0] ? r_win[w_tap] : r_wt[w_tap];
  assign acc_cstart = (r_state == S_START) && !clear;
  assign res_valid  = (r_state == S_EMIT) && !clear;
  assign frame_done = res_valid && r_last;
  assign res_data   = r_res;
  assign res_row    = r_orow;
  assign res_col    = r_ocol;

  conv_line_buffer #(
    .BIT_LENGTH (BIT_LENGTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .CW         (CW)
  ) u_lb (
    .Clk   (Clk),
    .i_we  (w_accept),
    .i_col (r_col),
    .i_pix (pix_data),
    .o_lb0 (w_lb0),
    .o_lb1 (w_lb1)
  );

  // Sequencer: fill, push 18 words, start, wait, emit.
  always_ff @(posedge Clk or negedge RstIn) begin
    if (!RstIn) begin
      r_state <= S_FILL;
      r_row   <= '0;
      r_col   <= '0;
      r_widx  <= '0;
      r_res   <= '0;
      r_orow  <= '0;
      r_ocol  <= '0;
      r_last  <= 1'b0;
    end else if (clear) begin
      r_state <= S_FILL;
      r_row   <= '0;
      r_col   <= '0;
      r_widx  <= '0;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        S_FILL: begin
          if (w_accept) begin
            r_col <= w_col_end ? '0 : r_col + CW'(1);
            if (w_col_end)
              r_row <= w_row_end ? '0 : r_row + RW'(1);
            if (w_win) begin
              r_state <= S_PUSH;
              r_widx  <= '0;
              r_orow  <= r_row - RW'(2);
              r_ocol  <= r_col - CW'(2);
              r_last  <= w_row_end && w_col_end;
            end
          end
        end
        S_PUSH: begin
          if (w_wr) begin
            if (r_widx == 5'(PAIR_WORDS - 1))
              r_state <= S_START;
            else
              r_widx <= r_widx + 5'd1;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (w_edge) begin
            r_res   <= acc_sum;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (r_last) begin
            r_row <= '0;
            r_col <= '0;
          end
          r_last  <= 1'b0;
          r_state <= S_FILL;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  // Previous cReady, so only a fresh rise is taken.
  always_ff @(posedge Clk or negedge RstIn) begin
    if (!RstIn) r_prev_rdy <= 1'b0;
    else        r_prev_rdy <= acc_cready;
  end

  // Weight file, writable only while filling.
  always_ff @(posedge Clk or negedge RstIn) begin
    if (!RstIn) begin
      for (int i = 0; i < WINDOW_TAPS; i++)
        r_wt[i] <= '0;
    end else if (wt_we && (r_state == S_FILL) &&
                 (wt_addr < 4'd9)) begin
      r_wt[wt_addr] <= wt_data;
    end
  end

  // Window shifts left; new right column from the line stores.
  always_ff @(posedge Clk or negedge RstIn) begin
    if (!RstIn) begin
      for (int i = 0; i < WINDOW_TAPS; i++)
        r_win[i] <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < 3; r++) begin
        r_win[3*r]   <= r_win[3*r+1];
        r_win[3*r+1] <= r_win[3*r+2];
      end
      r_win[2] <= w_lb1;
      r_win[5] <= w_lb0;
      r_win[8] <= pix_data;
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Randomised bench for conv_window_feeder with a
// frame-level reference model and accelerator model.
module tb_conv_window_feeder;

  localparam int W = 4;
  localparam int H = 4;

  logic       Clk = 0;
  logic       RstIn = 1;
  logic       clear = 0;
  logic       wt_we = 0;
  logic [3:0] wt_addr = 0;
  logic [7:0] wt_data = 0;
  logic       pix_valid = 0;
  logic       pix_ready;
  logic [7:0] pix_data = 0;
  logic       acc_wr;
  logic [7:0] acc_data;
  logic       acc_full = 0;
  logic       acc_cstart;
  logic       acc_cready = 0;
  logic [7:0] acc_sum = 0;
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_row;
  logic [1:0] res_col;
  logic       frame_done;

  int n_chk = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  conv_window_feeder #(
    .BIT_LENGTH (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .Clk        (Clk),
    .RstIn      (RstIn),
    .clear      (clear),
    .wt_we      (wt_we),
    .wt_addr    (wt_addr),
    .wt_data    (wt_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .acc_wr     (acc_wr),
    .acc_data   (acc_data),
    .acc_full   (acc_full),
    .acc_cstart (acc_cstart),
    .acc_cready (acc_cready),
    .acc_sum    (acc_sum),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_row    (res_row),
    .res_col    (res_col),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [8:0][7:0] w;
    logic [8:0][7:0] p;
    logic [7:0]      sum;
    logic [1:0]      row;
    logic [1:0]      col;
    logic            last;
  } exp_t;

  logic [7:0] m_wt  [9];
  logic [7:0] m_img [H][W];
  int         mr = 0;
  int         mc = 0;
  exp_t       exp_q[$];
  logic [7:0] res_log[$];
  logic [7:0] first_words[$];
  bit         grab = 0;
  bit         abort = 0;
  bit         pre_hi = 0;
  bit         stall5 = 0;

  // Reference: a window is the 3x3 block ending at the
  // pixel just accepted; result is the truncated dot product.
  task automatic model_accept(input logic [7:0] d);
    exp_t e;
    int   s;
    m_img[mr][mc] = d;
    if (mr >= 2 && mc >= 2) begin
      s = 0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          e.w[i*3+j] = m_wt[i*3+j];
          e.p[i*3+j] = m_img[mr-2+i][mc-2+j];
          s += int'(m_wt[i*3+j]) *
               int'(m_img[mr-2+i][mc-2+j]);
        end
      e.sum  = s[7:0];
      e.row  = 2'(mr - 2);
      e.col  = 2'(mc - 2);
      e.last = (mr == H-1) && (mc == W-1);
      exp_q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end
  endtask

  task automatic model_restart();
    exp_q.delete();
    mr = 0;
    mc = 0;
  endtask

  task automatic send_pix(input logic [7:0] d,
                          input bit we = 0,
                          input logic [3:0] a = 0,
                          input logic [7:0] wd = 0);
    int t = 0;
    repeat ($urandom_range(0, 2)) @(negedge Clk);
    @(negedge Clk);
    pix_valid = 1;
    pix_data  = d;
    #1;
    while (!pix_ready && t < 400) begin
      @(negedge Clk);
      #1;
      t++;
    end
    chk("pix_accept_in_time", t < 400, 1);
    if (t >= 400) begin
      pix_valid = 0;
      return;
    end
    if (we) begin
      wt_we   = 1;
      wt_addr = a;
      wt_data = wd;
    end
    @(posedge Clk);
    if (we && a < 9) m_wt[a] = wd;
    model_accept(d);
    #1;
    pix_valid = 0;
    wt_we     = 0;
  endtask

  task automatic wt_write(input logic [3:0] a,
                          input logic [7:0] d,
                          input bit in_fill);
    @(negedge Clk);
    wt_we   = 1;
    wt_addr = a;
    wt_data = d;
    @(posedge Clk);
    if (in_fill && a < 9) m_wt[a] = d;
    #1;
    wt_we = 0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge Clk);
      t++;
    end
    chk("idle_in_time", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge Clk);
  endtask

  task automatic run_frame(input bit rnd, input int base);
    for (int i = 0; i < W*H; i++)
      send_pix(rnd ? 8'($urandom) : 8'(base + i));
    wait_idle();
  endtask

  task automatic rand_weights();
    for (int a = 0; a < 9; a++)
      wt_write(4'(a), 8'($urandom), 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_pix_ready", pix_ready, 1);
    chk("rst_acc_wr", acc_wr, 0);
    chk("rst_acc_data", acc_data, 0);
    chk("rst_cstart", acc_cstart, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_row", res_row, 0);
    chk("rst_res_col", res_col, 0);
    chk("rst_frame_done", frame_done, 0);
  endtask

  // Accelerator: collects words, sums pairs, answers
  // with a low-then-high cReady after a random delay.
  initial begin : acc_model
    logic [7:0] q[$];
    exp_t       e;
    int         cnt;
    int         hold;
    int         stall;
    int         s;
    bit         busy;
    bit         seen_full;
    logic [7:0] pend;
    logic [7:0] held;
    cnt = 0; hold = 0; stall = 0;
    busy = 0; seen_full = 0;
    pend = 0; held = 0;
    forever begin
      @(negedge Clk);
      if (abort) begin
        acc_full   = 0;
        acc_cready = 0;
        busy  = 0;
        stall = 0;
        hold  = 0;
        q.delete();
      end else begin
        if (stall > 0) begin
          acc_full = 1;
          stall--;
        end else begin
          acc_full = 0;
          if (q.size() >= 1 && q.size() <= 17) begin
            if (stall5 && q.size() == 5) begin
              acc_full = 1;
              stall    = 4;
              stall5   = 0;
            end else if ($urandom_range(0, 7) == 0) begin
              acc_full = 1;
              stall    = $urandom_range(0, 3);
            end
          end
        end
        if (busy) begin
          if (cnt > 2) cnt--;
          else if (cnt == 2) begin
            acc_cready = 0;
            acc_sum    = 8'($urandom);
            cnt--;
          end else begin
            acc_cready = 1;
            acc_sum    = pend;
            busy = 0;
            hold = $urandom_range(1, 30);
          end
        end else if (pre_hi) begin
          acc_cready = 1;
          acc_sum    = 8'hEE;
        end else if (hold > 0) begin
          hold--;
          if (hold == 0) begin
            acc_cready = 0;
            acc_sum    = 8'($urandom);
          end
        end
      end
      #1;
      if (!abort) begin
        if (acc_full) begin
          chk("wr_low_when_full", acc_wr, 0);
          if (seen_full) chk("data_held", acc_data, held);
          held = acc_data;
          seen_full = 1;
        end else begin
          seen_full = 0;
        end
        if (acc_wr && !acc_full) q.push_back(acc_data);
        if (acc_cstart) begin
          chk("words_per_window", q.size(), 18);
          chk("start_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            for (int k = 0; k < 18 && k < q.size(); k++)
              chk($sformatf("word%0d", k), q[k],
                  k[0] ? e.p[k/2] : e.w[k/2]);
          end
          s = 0;
          for (int k = 0; 2*k+1 < q.size(); k++)
            s += int'(q[2*k]) * int'(q[2*k+1]);
          pend = s[7:0];
          if (grab) begin
            first_words = q;
            grab = 0;
          end
          q.delete();
          busy = 1;
          cnt  = $urandom_range(2, 8);
        end
        if (res_valid) begin
          chk("res_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("res_data", res_data, e.sum);
            chk("res_row", res_row, e.row);
            chk("res_col", res_col, e.col);
            chk("frame_done", frame_done, e.last);
            res_log.push_back(res_data);
          end
        end else if (frame_done) begin
          chk("frame_done_alone", res_valid, 1);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [7:0] t1 [4];
    logic [7:0] t2 [18];
    int         t;
    t1 = '{8'd54, 8'd63, 8'd90, 8'd99};
    t2 = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3,
           8'd4, 8'd5, 8'd5, 8'd6, 8'd6, 8'd7,
           8'd7, 8'd9, 8'd8, 8'd10, 8'd9, 8'd11};
    for (int a = 0; a < 9; a++) m_wt[a] = 0;

    #1 RstIn = 0;
    repeat (3) @(negedge Clk);
    #1 chk_reset_outs();
    @(negedge Clk);
    RstIn = 1;

    // Unit weights, ramp image.
    for (int a = 0; a < 9; a++) wt_write(4'(a), 8'd1, 1);
    res_log.delete();
    run_frame(0, 1);
    chk("t1_count", res_log.size(), 4);
    for (int k = 0; k < 4 && k < res_log.size(); k++)
      chk($sformatf("t1_res%0d", k), res_log[k], t1[k]);

    // Word order for the first window.
    for (int a = 0; a < 9; a++)
      wt_write(4'(a), 8'(a + 1), 1);
    grab = 1;
    run_frame(0, 1);
    chk("t2_count", first_words.size(), 18);
    for (int k = 0; k < 18 && k < first_words.size(); k++)
      chk($sformatf("t2_word%0d", k), first_words[k], t2[k]);

    // Long full stall inside a push.
    rand_weights();
    stall5 = 1;
    run_frame(1, 0);

    // cReady already high when a window starts.
    rand_weights();
    pre_hi = 1;
    repeat (3) @(negedge Clk);
    run_frame(1, 0);
    pre_hi = 0;
    repeat (40) @(negedge Clk);

    // Weight writes during push dropped, in fill kept.
    rand_weights();
    wt_write(4'd4, 8'h11, 1);
    for (int i = 0; i < W*H; i++) begin
      if (i == 4)
        send_pix(8'($urandom), 1, 4'd13, 8'h33);
      else if (i == 12)
        send_pix(8'($urandom), 1, 4'd0, 8'h5A);
      else
        send_pix(8'($urandom));
      if (i == 10) wt_write(4'd4, 8'h77, 0);
    end
    wait_idle();

    // Async reset while waiting for cReady.
    rand_weights();
    for (int i = 0; i < 11; i++) send_pix(8'($urandom));
    t = 0;
    @(negedge Clk);
    #1;
    while (!acc_cstart && t < 400) begin
      @(negedge Clk);
      #1;
      t++;
    end
    chk("start_seen", t < 400, 1);
    @(negedge Clk);
    abort = 1;
    RstIn = 0;
    #1 chk_reset_outs();
    for (int a = 0; a < 9; a++) m_wt[a] = 0;
    model_restart();
    @(negedge Clk);
    RstIn = 1;
    repeat (2) @(negedge Clk);
    abort = 0;
    rand_weights();
    run_frame(1, 0);

    // Synchronous clear mid-push.
    for (int i = 0; i < 11; i++) send_pix(8'($urandom));
    t = 0;
    @(negedge Clk);
    #1;
    while (!acc_wr && t < 400) begin
      @(negedge Clk);
      #1;
      t++;
    end
    chk("push_seen", t < 400, 1);
    repeat (3) @(negedge Clk);
    abort = 1;
    clear = 1;
    #1;
    chk("clr_acc_wr", acc_wr, 0);
    chk("clr_cstart", acc_cstart, 0);
    chk("clr_res_valid", res_valid, 0);
    @(posedge Clk);
    #1;
    clear = 0;
    chk("clr_pix_ready", pix_ready, 1);
    model_restart();
    repeat (2) @(negedge Clk);
    abort = 0;
    run_frame(1, 0);

    // Free-running random frames.
    for (int f = 0; f < 3; f++) begin
      rand_weights();
      run_frame(1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
